// File: rtl/key_pkg.sv
// Shared types and default parameter values for the key press filter.
package key_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } key_rpt_state_t;

    localparam int KEY_DEBOUNCE_DFLT  = 4;
    localparam int KEY_RPT_DELAY_DFLT = 50;
    localparam int KEY_RPT_PERIOD_DFLT = 10;

endpackage

// File: rtl/key_debounce.sv
// Debouncer: held follows key_sync only after DEBOUNCE_CYCLES consecutive differing samples.
// rise/fall are registered one-cycle pulses aligned with the cycle held changes.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_sync,
    output logic held,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] stab_cnt;
    logic       flip;

    // The run completes on the sample that would bring the count to DEBOUNCE_CYCLES.
    assign flip = (key_sync != held) && (stab_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            stab_cnt <= '0;
            held     <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            // NOTE: non-blocking so rise/fall see the pre-edge held, like real flops.
            rise <= flip && !held;
            fall <= flip && held;
            if ((key_sync == held) || flip) begin
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + 8'd1;
            end
            if (flip) begin
                held <= !held;
            end
        end
    end

endmodule

// File: rtl/key_press_filter.sv
// Key press filter: debounced level, press/release pulses, optional auto-repeat.
// Auto-repeat FSM is built only when KEY_AUTOREPEAT_EN is defined.
module key_press_filter
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DFLT,
    parameter int REPEAT_DELAY    = KEY_RPT_DELAY_DFLT,
    parameter int REPEAT_PERIOD   = KEY_RPT_PERIOD_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_sync,
    output logic press,
    output logic held,
    output logic release_pulse
);

    if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 255) ||
        (REPEAT_DELAY < 1) || (REPEAT_DELAY > 65535) ||
        (REPEAT_PERIOD < 1) || (REPEAT_PERIOD > 65535)) begin : g_bad_param
        $error("key_press_filter: parameter out of range");
    end

    logic rise;
    logic fall;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .key_sync(key_sync),
        .held    (held),
        .rise    (rise),
        .fall    (fall)
    );

    assign release_pulse = fall;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [15:0] DELAY_LAST  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] PERIOD_LAST = 16'(REPEAT_PERIOD - 1);

    key_rpt_state_t state;
    key_rpt_state_t state_nxt;
    logic [15:0]    rpt_cnt;
    logic           fire;

    // rpt_cnt counts cycles elapsed minus one, so a match fires in the target cycle itself.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        state_nxt = state;
        fire      = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) state_nxt = S_DELAY;
            end
            S_DELAY: begin
                if (fall) begin
                    state_nxt = S_IDLE;
                end else if (rpt_cnt == DELAY_LAST) begin
                    fire      = 1'b1;
                    state_nxt = S_REPEAT;
                end
            end
            S_REPEAT: begin
                if (fall) begin
                    state_nxt = S_IDLE;
                end else if (rpt_cnt == PERIOD_LAST) begin
                    fire = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            rpt_cnt <= '0;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || fire) begin
                rpt_cnt <= '0;
            end else if ((state != S_IDLE) && (rpt_cnt != 16'hFFFF)) begin
                rpt_cnt <= rpt_cnt + 16'd1;
            end
        end
    end

    // A falling held already blocks fire, so press and release never coincide.
    assign press = rise | fire;
`else
    assign press = rise;
`endif

endmodule

// File: tb/tb_key_press_filter.sv
// Self-checking bench for key_press_filter; adapts to KEY_AUTOREPEAT_EN.
module tb_key_press_filter;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_sync = 1'b0;
    logic press, held, release_pulse;

    always #5 clk = ~clk;

    key_press_filter #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_sync     (key_sync),
        .press        (press),
        .held         (held),
        .release_pulse(release_pulse)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: debounced level plus age (cycles since the accepted press).
    logic m_held = 1'b0;
    logic m_press = 1'b0;
    logic m_release = 1'b0;
    int   m_run = 0;
    int   m_age = 0;

    // Drive one cycle of inputs, advance the model across the edge, settle after it.
    task automatic step(input logic k, input logic r);
        logic rose, fell;
        key_sync = k;
        reset    = r;
        @(posedge clk);
        rose = 1'b0;
        fell = 1'b0;
        if (r) begin
            m_held = 1'b0;
            m_run  = 0;
            m_age  = 0;
        end else if (k != m_held) begin
            m_run++;
            if (m_run == DB) begin
                m_held = ~m_held;
                m_run  = 0;
                rose   = m_held;
                fell   = ~m_held;
            end
        end else begin
            m_run = 0;
        end
        if (rose) m_age = 0;
        else if (m_held) m_age++;
        m_release = fell;
        m_press   = rose || (AR && m_held && (m_age >= RD) && ((m_age - RD) % RP == 0));
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            n_checks++;
            if ({press, held, release_pulse} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b expected 000", {press, held, release_pulse});
            end
        end
        // Key still down after reset: a full debounce run is required.
        for (int i = 0; i < DB; i++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if ({press, held, release_pulse} !== ((i == DB - 1) ? 3'b110 : 3'b000)) begin
                n_fail++;
                $display("FAIL reset_keydown_run[%0d]: got %b", i, {press, held, release_pulse});
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if ({press, held, release_pulse} !== {m_press, m_held, m_release}) begin
                n_fail++;
                $display("FAIL reset_release[%0d]: got %b expected %b", i,
                         {press, held, release_pulse}, {m_press, m_held, m_release});
            end
        end
    endtask

    task automatic test_clean_press();
        for (int i = 0; i < DB + 1; i++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if ({press, held, release_pulse} !== ((i == DB - 1) ? 3'b110 : (i == DB) ? 3'b010 : 3'b000)) begin
                n_fail++;
                $display("FAIL clean_press[%0d]: got %b", i, {press, held, release_pulse});
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if ({press, held, release_pulse} !== {m_press, m_held, m_release}) begin
                n_fail++;
                $display("FAIL clean_release[%0d]: got %b expected %b", i,
                         {press, held, release_pulse}, {m_press, m_held, m_release});
            end
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < DB + 5; i++) begin
            step((i < DB - 1) ? 1'b1 : 1'b0, 1'b0);
            n_checks++;
            if ({press, held, release_pulse} !== 3'b000) begin
                n_fail++;
                $display("FAIL glitch_reject[%0d]: got %b expected 000", i, {press, held, release_pulse});
            end
        end
    endtask

    task automatic test_autorepeat();
        int presses = 0;
        int expected;
        for (int i = 0; i < DB + 40; i++) begin
            step(1'b1, 1'b0);
            if (press === 1'b1) presses++;
            n_checks++;
            if ({press, held, release_pulse} !== {m_press, m_held, m_release}) begin
                n_fail++;
                $display("FAIL autorepeat[%0d]: got %b expected %b", i,
                         {press, held, release_pulse}, {m_press, m_held, m_release});
            end
        end
        // Initial press plus repeats at ages RD, RD+RP, ... up to age 40.
        expected = 1 + (AR ? ((40 - RD) / RP + 1) : 0);
        n_checks++;
        if (presses != expected) begin
            n_fail++;
            $display("FAIL autorepeat_count: got %0d expected %0d", presses, expected);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if ({press, held, release_pulse} !== {m_press, m_held, m_release}) begin
                n_fail++;
                $display("FAIL autorepeat_release[%0d]: got %b expected %b", i,
                         {press, held, release_pulse}, {m_press, m_held, m_release});
            end
        end
    endtask

    task automatic test_release();
        logic k;
        // Press, 2-sample low glitch, high again, then a real release.
        for (int i = 0; i < 21; i++) begin
            k = (i < 8) ? 1'b1 : (i < 10) ? 1'b0 : (i < 13) ? 1'b1 : 1'b0;
            step(k, 1'b0);
            n_checks++;
            if ({press, held, release_pulse} !== {m_press, m_held, m_release}) begin
                n_fail++;
                $display("FAIL release_seq[%0d]: got %b expected %b", i,
                         {press, held, release_pulse}, {m_press, m_held, m_release});
            end
            if (i >= 4 && i < 13) begin
                n_checks++;
                if ({held, release_pulse} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL release_glitch[%0d]: got held/release %b expected 10", i, {held, release_pulse});
                end
            end
            if (i == 16) begin
                n_checks++;
                if ({press, held, release_pulse} !== 3'b001) begin
                    n_fail++;
                    $display("FAIL release_pulse: got %b expected 001", {press, held, release_pulse});
                end
            end
        end
    endtask

    task automatic test_cancel();
        // Held falls in exactly the cycle of the first repeat (age RD).
        for (int i = 0; i < DB + RD; i++) begin
            step((i < DB + RD - DB) ? 1'b1 : 1'b0, 1'b0);
            n_checks++;
            if ({press, held, release_pulse} !== {m_press, m_held, m_release}) begin
                n_fail++;
                $display("FAIL cancel_seq[%0d]: got %b expected %b", i,
                         {press, held, release_pulse}, {m_press, m_held, m_release});
            end
        end
        n_checks++;
        if ({press, held, release_pulse} !== 3'b001) begin
            n_fail++;
            $display("FAIL cancel_repeat: got %b expected 001", {press, held, release_pulse});
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_repeat();
        for (int i = 0; i < DB + 12; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        n_checks++;
        if ({press, held, release_pulse} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b expected 000", {press, held, release_pulse});
        end
        for (int i = 0; i < DB + 2; i++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if ({press, held, release_pulse} !== ((i == DB - 1) ? 3'b110 : (i < DB - 1) ? 3'b000 : 3'b010)) begin
                n_fail++;
                $display("FAIL mid_reset_repress[%0d]: got %b", i, {press, held, release_pulse});
            end
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic lvl, r;
        int   len;
        for (int blk = 0; blk < 120; blk++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            for (int j = 0; j < len; j++) begin
                r = ($urandom_range(0, 99) == 0);
                step(lvl, r);
                n_checks++;
                if ({press, held, release_pulse} !== {m_press, m_held, m_release}) begin
                    n_fail++;
                    $display("FAIL random[%0d.%0d]: got %b expected %b", blk, j,
                             {press, held, release_pulse}, {m_press, m_held, m_release});
                end
                n_checks++;
                if ((press & release_pulse) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_exclusive[%0d.%0d]: press and release both high", blk, j);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_autorepeat();
        test_release();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        test_cancel();
        test_reset_mid_repeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
